// File: rtl/spike_bus_pkg.sv
// Shared definitions for the spike-event bus: neuron count, FSM states,
// phase-counter width and the default event envelope.
package spike_bus_pkg;

  localparam int NUM_NEURONS = 8;
  localparam int PHASE_W     = 4;

  // Default envelope: setup + strobe + hold + gap = 5-cycle event period.
  localparam int unsigned DEF_SETUP  = 1;
  localparam int unsigned DEF_STROBE = 1;
  localparam int unsigned DEF_HOLD   = 1;
  localparam int unsigned DEF_GAP    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef logic [NUM_NEURONS:1] nvec_t;
  typedef logic [PHASE_W-1:0]   phase_t;

endpackage

// File: rtl/spike_rr_arbiter.sv
// Combinational round-robin arbiter: searches the pending vector starting
// one past the last-granted neuron, wrapping 8 -> 1.
module spike_rr_arbiter
  import spike_bus_pkg::*;
(
  input  nvec_t       pend_i,
  input  logic [3:0]  ptr_i,      // last-granted neuron number, 1..8
  output nvec_t       grant_o,    // one-hot winner
  output logic [3:0]  grant_num_o,
  output logic        valid_o
);

  logic [3:0] n;

  // First pending neuron in rotated order wins.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    grant_o     = '0;
    grant_num_o = '0;
    valid_o     = 1'b0;
    n           = '0;
    for (int i = 1; i <= NUM_NEURONS; i++) begin
      n = 4'(((int'(ptr_i) - 1 + i) % NUM_NEURONS) + 1);
      if (!valid_o && pend_i[n]) begin
        grant_o[n]  = 1'b1;
        grant_num_o = n;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_event_tx.sv
// Spike-event bus transmitter: latches per-neuron spike requests, picks one
// round-robin, and plays it out as a setup/strobe/hold/gap envelope on the
// one-hot index bus and registered spike strobe. Counts lost requests.
module spike_event_tx
  import spike_bus_pkg::*;
#(
  parameter int unsigned p_setup  = DEF_SETUP,
  parameter int unsigned p_strobe = DEF_STROBE,
  parameter int unsigned p_hold   = DEF_HOLD,
  parameter int unsigned p_gap    = DEF_GAP
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [8:1]  i_spike,
  output logic [8:1]  o_index,
  output logic        o_spike,
  output logic        o_busy,
  output logic        o_drop,
  output logic [7:0]  o_drop_count
);

  state_e     state_q, state_d;
  phase_t     phase_q, phase_d;
  nvec_t      pend_q, pend_d;
  logic [3:0] ptr_q, ptr_d;
  nvec_t      index_q, index_d;
  logic       spike_q, spike_d;
  logic       drop_q, drop_d;
  logic [7:0] cnt_q, cnt_d;

  nvec_t      gnt;
  logic [3:0] gnt_num;
  logic       gnt_valid;
  logic       grant_en;
  nvec_t      clr;
  logic       drop_hit;

  spike_rr_arbiter u_arb (
    .pend_i      (pend_q),
    .ptr_i       (ptr_q),
    .grant_o     (gnt),
    .grant_num_o (gnt_num),
    .valid_o     (gnt_valid)
  );

  // State, envelope outputs, pending set and drop counter registers.
  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset clears every register, including the pending
    // vector, so an in-flight event is aborted with no partial hold.
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pend_q  <= '0;
      ptr_q   <= 4'd8;
      index_q <= '0;
      spike_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      index_q <= index_d;
      spike_q <= spike_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Envelope sequencing, grant, pending update and drop detection.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    ptr_d    = ptr_q;
    index_d  = index_q;
    spike_d  = spike_q;
    grant_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_en = gnt_valid;
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          state_d = ST_STROBE;
          phase_d = phase_t'(p_strobe - 1);
          spike_d = 1'b1;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (phase_q == '0) begin
          state_d = ST_HOLD;
          phase_d = phase_t'(p_hold - 1);
          spike_d = 1'b0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == '0) begin
          state_d = ST_GAP;
          phase_d = phase_t'(p_gap - 1);
          index_d = '0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_q == '0) begin
          if (gnt_valid) grant_en = 1'b1;
          else           state_d  = ST_IDLE;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_en) begin
      state_d = ST_SETUP;
      phase_d = phase_t'(p_setup - 1);
      index_d = gnt;
      ptr_d   = gnt_num;
    end

    // A request on the granted bit re-arms it (set wins); any other request
    // on an already-pending bit is lost.
    clr      = grant_en ? gnt : '0;
    drop_hit = |(i_spike & pend_q & ~clr);
    pend_d   = (pend_q & ~clr) | i_spike;
    drop_d   = drop_hit;
    cnt_d    = (drop_hit && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  assign o_index      = index_q;
  assign o_spike      = spike_q;
  assign o_busy       = (pend_q != '0) || (state_q != ST_IDLE);
  assign o_drop       = drop_q;
  assign o_drop_count = cnt_q;

endmodule

// File: tb/tb_spike_event_tx.sv
// Self-checking bench for spike_event_tx: an event-age reference model runs
// alongside the DUT, plus scenario tasks with directed expectations.
module tb_spike_event_tx;

  localparam int S   = 1;
  localparam int ST  = 1;
  localparam int H   = 1;
  localparam int G   = 2;
  localparam int PER = S + ST + H + G;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:1] i_spike = '0;
  logic [8:1] o_index;
  logic       o_spike;
  logic       o_busy;
  logic       o_drop;
  logic [7:0] o_drop_count;

  int total = 0;
  int bad   = 0;

  spike_event_tx #(
    .p_setup (S),
    .p_strobe(ST),
    .p_hold  (H),
    .p_gap   (G)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_spike     (i_spike),
    .o_index     (o_index),
    .o_spike     (o_spike),
    .o_busy      (o_busy),
    .o_drop      (o_drop),
    .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: pending set, last winner, and age of the event in flight.
  logic [8:1] m_pend = '0;
  int         m_ptr = 8;
  bit         m_active = 1'b0;
  int         m_age = 0;
  int         m_win = 1;
  bit         m_drop = 1'b0;
  int         m_cnt = 0;
  logic [8:1] m_cl;
  bit         m_found;
  int         m_n;

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_pend = '0; m_ptr = 8; m_active = 0; m_age = 0; m_drop = 0; m_cnt = 0;
    end else begin
      m_cl = '0;
      if ((!m_active || m_age == PER - 1) && m_pend != '0) begin
        m_found = 0;
        for (int k = 1; k <= 8; k++) begin
          m_n = (m_ptr + k - 1) % 8 + 1;
          if (!m_found && m_pend[m_n]) begin
            m_found = 1;
            m_win = m_n;
          end
        end
        m_cl[m_win] = 1'b1;
        m_ptr = m_win;
        m_active = 1;
        m_age = 0;
      end else if (m_active) begin
        m_age++;
        if (m_age == PER) m_active = 0;
      end
      m_drop = |(i_spike & m_pend & ~m_cl);
      if (m_drop && m_cnt < 255) m_cnt++;
      m_pend = (m_pend & ~m_cl) | i_spike;
    end
  end

  // Per-cycle comparison against the model, plus grant-order logging.
  logic [8:1]  e_idx;
  bit          e_spk, e_busy;
  logic [8:1]  prev_idx = '0;
  logic [63:0] obs_code = '0;
  int          obs_n = 0;
  int          drop_pulses = 0;

  always @(negedge i_clk) begin
    e_idx  = (m_active && m_age < S + ST + H) ? (8'd1 << (m_win - 1)) : 8'd0;
    e_spk  = m_active && m_age >= S && m_age < S + ST;
    e_busy = (m_pend != '0) || m_active;
    total++;
    if (o_index !== e_idx) begin
      bad++; $display("FAIL mon_index t=%0t got=%h want=%h", $time, o_index, e_idx);
    end
    total++;
    if (o_spike !== e_spk) begin
      bad++; $display("FAIL mon_spike t=%0t got=%b want=%b", $time, o_spike, e_spk);
    end
    total++;
    if (o_busy !== e_busy) begin
      bad++; $display("FAIL mon_busy t=%0t got=%b want=%b", $time, o_busy, e_busy);
    end
    total++;
    if (o_drop !== m_drop) begin
      bad++; $display("FAIL mon_drop t=%0t got=%b want=%b", $time, o_drop, m_drop);
    end
    total++;
    if (o_drop_count !== 8'(m_cnt)) begin
      bad++; $display("FAIL mon_drop_count t=%0t got=%0d want=%0d", $time, o_drop_count, m_cnt);
    end
    if (o_drop === 1'b1) drop_pulses++;
    if (o_index != '0 && prev_idx == '0) begin
      for (int n = 1; n <= 8; n++)
        if (o_index[n]) obs_code = {obs_code[59:0], 4'(n)};
      obs_n++;
    end
    prev_idx = o_index;
  end

  task automatic cyc(input logic [8:1] s);
    @(negedge i_clk);
    i_spike = s;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_spike = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    obs_code = '0;
    obs_n = 0;
    drop_pulses = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && o_busy; c++) cyc('0);
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL wait_idle still busy after %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_index, o_spike, o_busy, o_drop, o_drop_count} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got idx=%h spk=%b busy=%b drop=%b cnt=%0d want all 0",
               o_index, o_spike, o_busy, o_drop, o_drop_count);
    end
  endtask

  task automatic test_single();
    logic [8:1] exp_idx [6] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    bit         exp_spk [6] = '{0, 0, 1, 0, 0, 0};
    do_reset();
    cyc(8'h04);
    for (int j = 0; j < 6; j++) begin
      cyc('0);
      total++;
      if (o_index !== exp_idx[j] || o_spike !== exp_spk[j]) begin
        bad++;
        $display("FAIL single_cycle%0d got idx=%h spk=%b want idx=%h spk=%b",
                 j, o_index, o_spike, exp_idx[j], exp_spk[j]);
      end
    end
    wait_idle(20);
    total++;
    if (o_drop_count !== 8'd0 || obs_code !== 64'h3 || obs_n != 1) begin
      bad++;
      $display("FAIL single_summary got cnt=%0d order=%h n=%0d want cnt=0 order=3 n=1",
               o_drop_count, obs_code, obs_n);
    end
  endtask

  task automatic test_burst();
    do_reset();
    cyc(8'hFF);
    cyc('0);
    wait_idle(100);
    total++;
    if (obs_code !== 64'h12345678 || obs_n != 8) begin
      bad++; $display("FAIL burst_order got=%h n=%0d want=12345678 n=8", obs_code, obs_n);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    cyc(8'h10);
    cyc('0);
    cyc(8'h51);
    cyc('0);
    wait_idle(60);
    total++;
    if (obs_code !== 64'h5715 || obs_n != 4) begin
      bad++; $display("FAIL rr_order got=%h n=%0d want=5715 n=4", obs_code, obs_n);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cyc(8'h01);
    cyc('0);
    cyc(8'h02);
    cyc(8'h02);
    cyc('0);
    wait_idle(40);
    total++;
    if (o_drop_count !== 8'd1 || drop_pulses != 1 || obs_code !== 64'h12 || obs_n != 2) begin
      bad++;
      $display("FAIL drop_once got cnt=%0d pulses=%0d order=%h want cnt=1 pulses=1 order=12",
               o_drop_count, drop_pulses, obs_code);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (400) cyc(8'h02);
    cyc('0);
    wait_idle(40);
    total++;
    if (o_drop_count !== 8'd255) begin
      bad++; $display("FAIL drop_saturate got=%0d want=255", o_drop_count);
    end
  endtask

  task automatic test_rerequest();
    do_reset();
    cyc(8'h04);
    cyc(8'h04);
    cyc('0);
    wait_idle(40);
    total++;
    if (o_drop_count !== 8'd0 || obs_code !== 64'h33 || obs_n != 2) begin
      bad++;
      $display("FAIL rerequest got cnt=%0d order=%h n=%0d want cnt=0 order=33 n=2",
               o_drop_count, obs_code, obs_n);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(8'h01);
    cyc('0);
    cyc(8'h20);
    for (int c = 0; c < 10 && o_spike !== 1'b1; c++) cyc('0);
    total++;
    if (o_spike !== 1'b1) begin
      bad++; $display("FAIL mid_reset_strobe got spk=%b want 1", o_spike);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    total++;
    if ({o_index, o_spike, o_busy, o_drop, o_drop_count} !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs got idx=%h spk=%b busy=%b want all 0",
               o_index, o_spike, o_busy);
    end
    obs_code = '0;
    obs_n = 0;
    cyc(8'h03);
    cyc('0);
    wait_idle(40);
    total++;
    if (obs_code !== 64'h12 || obs_n != 2) begin
      bad++; $display("FAIL mid_reset_order got=%h n=%0d want=12 n=2", obs_code, obs_n);
    end
  endtask

  task automatic test_random();
    logic [8:1] s;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s = '0;
      for (int b = 1; b <= 8; b++) s[b] = ($urandom_range(11) == 0);
      @(negedge i_clk);
      i_spike = s;
      i_rst_n = ($urandom_range(249) != 0);
    end
    cyc('0);
    i_rst_n = 1'b1;
    wait_idle(200);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fairness();
    test_drop();
    test_saturate();
    test_rerequest();
    test_mid_reset();
    test_random();
    @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_tx.md
# spike_event_tx

Transmit side of the shared spike-event bus. Collects single-cycle spike requests from up to 8 neurons and serialises them onto the one-hot index bus plus spike strobe consumed by the per-synapse pulse receivers. Each event is transmitted with a fixed setup/strobe/hold/gap envelope, so a receiver captures the index before the strobe edge and finishes its own clear cycle before the next event. Sits between the neuron array outputs and the synapse fabric.

## Interface

- p_setup, 1, cycles o_index is stable before o_spike rises (1..15)
- p_strobe, 1, cycles o_spike stays high (1..15)
- p_hold, 1, cycles o_index stays stable after o_spike falls (1..15)
- p_gap, 2, cycles o_index = 0 between events (2..15, covers receiver clear cycle)

- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_spike  in  [8:1]  per-neuron spike request; bit n high for one cycle = one event for neuron n
- o_index  out  [8:1]  one-hot index of event on bus; 0 when bus idle
- o_spike  out  1  event strobe; registered, glitch-free (receivers use it as a clock)
- o_busy  out  1  high while any event is pending or in flight
- o_drop  out  1  one-cycle pulse: a request was lost
- o_drop_count  out  [7:0]  lost-request count, saturates at 255

## Operation

- States: IDLE, SETUP, STROBE, HOLD, GAP; 4-bit phase counter.
- Pending register r_pend[8:1]: set by i_spike[n] on each edge.
- Drop: i_spike[n] high while r_pend[n] already set and not cleared that edge -> o_drop = 1 next cycle, o_drop_count += 1 (saturating at 255). Multiple drops in one edge count as one pulse/+1.
- Simultaneous set and clear of the same bit (granted edge): set wins; bit stays pending, no drop.
- Grant: round-robin over r_pend, starting at last-granted index + 1, wrapping 8 -> 1. After reset the pointer is 8, so first grant is the lowest pending index.
- At grant edge: o_index <= one-hot of winner, r_pend[winner] cleared, pointer <= winner, enter SETUP.
- IDLE: o_index = 0, o_spike = 0; grant when r_pend != 0.
- SETUP (p_setup cycles) -> STROBE: o_spike = 1 for p_strobe cycles -> HOLD: o_spike = 0, o_index held for p_hold cycles -> GAP: o_index = 0 for p_gap cycles.
- GAP end: grant directly if r_pend != 0, else IDLE.
- o_busy = (r_pend != 0) or state != IDLE.
- o_index and o_spike never change on the same edge.

## Timing

- Reset (i_rst_n low at an edge): next cycle o_index = 0, o_spike = 0, o_busy = 0, o_drop = 0, o_drop_count = 0, r_pend = 0, pointer = 8, state IDLE. Mid-event reset aborts the event; o_spike drops immediately, with no partial hold.
- Latency: i_spike[n] sampled at edge k -> o_index valid after edge k+1 -> o_spike high after edge k+1+p_setup.
- Event period: p_setup+p_strobe+p_hold+p_gap cycles (default 5) back-to-back; +1 cycle when leaving IDLE.
- Sustained throughput: 1 event / period. Requests arriving faster than this for one neuron are dropped.

## Structure

- Package spike_bus_pkg: NUM_NEURONS = 8, state enum, phase-counter width (4), default envelope constants.
- Sub-module spike_rr_arbiter: combinational 8-way round-robin (r_pend, pointer -> one-hot grant, valid). The FSM, counters and drop logic stay in spike_event_tx.

## Test plan

- Single event: i_spike = 8'b0000_0100 one cycle at edge k -> o_index = 0x04 for cycles k+2..k+4, o_spike high only in cycle k+3, o_index = 0 for 2 cycles, o_drop_count = 0.
- Burst: i_spike = 0xFF one cycle -> 8 events in order 1,2,...,8, each 5 cycles apart; o_busy low only after the last GAP.
- Round-robin fairness: after neuron 5 granted, r_pend = {1,5,7} -> next grants 7, then 1, then 5.
- Drop: i_spike[2] at edges k and k+1 while bus busy with neuron 1 -> one o_drop pulse, o_drop_count = 1; neuron 2 sent once. 300 such drops -> count stays 255.
- Re-request during own event: i_spike[3] asserted at the grant edge of neuron 3 -> no drop, neuron 3 sent a second time after GAP.
- Reset mid-STROBE: i_rst_n low one edge while o_spike = 1 -> next cycle all outputs 0, pending events lost, next request served from neuron 1 priority.
